// File: rtl/song_sequencer_pkg.sv
// Shared widths, note record and FSM state encoding for the song sequencer.
// Imported by the ROM interface, the timer and the sequencer top.
package song_sequencer_pkg;

    localparam int OCTAVE_BITS   = 3;
    localparam int NOTE_BITS     = 4;
    localparam int LENGTH_BITS   = 3;
    localparam int SONG_CNT_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One song entry; a length of zero marks the end of the song.
    typedef struct packed {
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
    } note_t;

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM bus: the sequencer drives the note index, the ROM answers combinationally.
// master = sequencer side, slave = ROM side.
interface song_sequencer_if;
    import song_sequencer_pkg::*;

    logic [SONG_CNT_BITS-1:0] rom_idx;
    logic [OCTAVE_BITS-1:0]   rom_octave;
    logic [NOTE_BITS-1:0]     rom_note;
    logic [LENGTH_BITS-1:0]   rom_length;

    modport master (output rom_idx, input rom_octave, rom_note, rom_length);
    modport slave  (input rom_idx, output rom_octave, rom_note, rom_length);

endinterface

// File: rtl/song_sequencer_seq_timer.sv
// seq_timer: loadable down-counter with hold and zero flag, shared by the PLAY
// and GAP phases. Clear and load take priority over hold.
module seq_timer #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         hold,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: assign a default first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (!hold && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM note by note, gating a buzzer for each
// note's duration with a silent gap between notes. Optional macro
// SONG_SEQUENCER_LOOP_EN makes the song repeat after its last note.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int DUR_W       = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     pause,
    input  logic [SONG_CNT_BITS-1:0] track_len,
    song_sequencer_if.master         rom,
    output logic [OCTAVE_BITS-1:0]   snd_octave,
    output logic [NOTE_BITS-1:0]     snd_note,
    output logic [LENGTH_BITS-1:0]   snd_length,
    output logic                     snd_play,
    output logic                     note_valid,
    output logic                     note_done,
    output logic                     hit_window,
    output logic                     busy,
    output logic                     done
);

    state_e                   state_q, state_d;
    logic [SONG_CNT_BITS-1:0] rom_idx_q, rom_idx_d;
    note_t                    snd_q, snd_d;
    logic                     play_gate_q, play_gate_d;
    logic                     note_valid_q, note_valid_d;
    logic                     note_done_q, note_done_d;
    logic                     hit_window_q, hit_window_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic             tmr_load;
    logic [DUR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [DUR_W-1:0] note_dur;

    // The timer is loaded with N-1 so a phase lasts exactly N unpaused cycles.
    assign note_dur = DUR_W'(rom.rom_length) * DUR_W'(UNIT_CYCLES);

    seq_timer #(.W(DUR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!en),
        .load     (tmr_load),
        .hold     (pause),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        rom_idx_d    = rom_idx_q;
        snd_d        = snd_q;
        note_valid_d = 1'b0;
        note_done_d  = 1'b0;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rom_idx_d = '0;
                        state_d   = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    snd_d = '{octave: rom.rom_octave, note: rom.rom_note, length: rom.rom_length};
                    if (rom.rom_length == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_val      = note_dur - DUR_W'(1);
                        note_valid_d = 1'b1;
                        state_d      = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tmr_zero && !pause) begin
                        tmr_load    = 1'b1;
                        tmr_val     = DUR_W'(GAP_CYCLES - 1);
                        note_done_d = 1'b1;
                        state_d     = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero && !pause) begin
                        if (rom_idx_q == track_len) begin
                            done_d = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
                            rom_idx_d = '0;
                            state_d   = ST_FETCH;
`else
                            state_d   = ST_DONE;
`endif
                        end else begin
                            rom_idx_d = rom_idx_q + SONG_CNT_BITS'(1);
                            state_d   = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Level outputs are decoded from the next state so they line up with it.
        hit_window_d = (state_d == ST_PLAY);
        busy_d       = (state_d != ST_IDLE);
        play_gate_d  = (state_d == ST_PLAY) && (snd_d.note != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rom_idx_q    <= '0;
            snd_q        <= '0;
            play_gate_q  <= 1'b0;
            note_valid_q <= 1'b0;
            note_done_q  <= 1'b0;
            hit_window_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_idx_q    <= rom_idx_d;
            snd_q        <= snd_d;
            play_gate_q  <= play_gate_d;
            note_valid_q <= note_valid_d;
            note_done_q  <= note_done_d;
            hit_window_q <= hit_window_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rom.rom_idx = rom_idx_q;
    assign snd_octave  = snd_q.octave;
    assign snd_note    = snd_q.note;
    assign snd_length  = snd_q.length;
    // Pause silences the buzzer in the same cycle it freezes the timer.
    assign snd_play    = play_gate_q && !pause;
    assign note_valid  = note_valid_q;
    assign note_done   = note_done_q;
    assign hit_window  = hit_window_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
